masked_and_dom: RTL and testbench

- Parametrised D-share masked AND/NAND gadget, domain-oriented masking (DOM-indep).
- Next-generation gadget for the 2D-flattening + randomization datapath; drop-in for the fixed 2-share AND cell.
- Takes D Boolean shares of a and b plus D(D-1)/2 fresh random bits, and returns D shares of a·b, or of ~(a·b) in NAND mode.
- Two-stage registered pipeline with a start/ready/done handshake.

---
 rtl/masked_and_dom_pkg.sv | 21 ++
 rtl/masked_and_dom_term_cell.sv | 33 +++
 rtl/masked_and_dom.sv | 100 ++++++++++
 tb/tb_masked_and_dom.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/masked_and_dom_pkg.sv
// Shared types and index helpers for the DOM-indep masked AND/NAND gadget.
// The pair-to-randomness mapping lives here so RTL and users agree on it.
package masked_pkg;

    localparam int D_MAX = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        COMPRESS = 1'b1
    } state_e;

    function automatic int rand_size(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Packs the upper-triangle pair (i<j) densely onto 0..rand_size(d)-1.
    function automatic int rand_idx(input int i, input int j, input int d);
        return i * d - i * (i + 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/masked_and_dom_term_cell.sv
// One registered DOM cross-term: q <= (a & b) ^ r when en, else hold.
// Each instance is its own flop so no cross-domain XOR is merged pre-register.
module dom_term_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic r,
    output logic q
);

    (* keep = "true", dont_touch = "true" *) logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = (a & b) ^ r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/masked_and_dom.sv
// D-share domain-oriented masked AND/NAND gadget, two-stage pipeline
// with start/ready/done handshake. Share domain i output uses row i only.
module masked_and_dom
    import masked_pkg::*;
#(
    parameter  int D         = 2,
    localparam int RAND_SIZE = rand_size(D)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 nand_sel,
    input  logic [0:D-1]         ina,
    input  logic [0:D-1]         inb,
    input  logic [0:RAND_SIZE-1] rin,
    output logic                 ready,
    output logic                 done,
    output logic [0:D-1]         out
);

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic   done_q, done_d;
    logic [0:D-1] out_q, out_d;
    logic [0:D-1][0:D-1] c_q;
    logic   accept;

    assign accept = start & (state_q == IDLE);

    for (genvar i = 0; i < D; i++) begin : g_row
        for (genvar j = 0; j < D; j++) begin : g_col
            logic r_t;
            if (i == j) begin : g_diag
                assign r_t = 1'b0;
            end else if (i < j) begin : g_up
                localparam int K = rand_idx(i, j, D);
                assign r_t = rin[K];
            end else begin : g_lo
                localparam int K = rand_idx(j, i, D);
                assign r_t = rin[K];
            end
            dom_term_cell u_cell (
                .clk (clk),
                .rst (rst),
                .en  (accept),
                .a   (ina[i]),
                .b   (inb[j]),
                .r   (r_t),
                .q   (c_q[i][j])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPRESS;
                    mode_d  = nand_sel;
                end
            end
            COMPRESS: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Compression reads only the registered terms of each row.
    always_comb begin
        out_d  = out_q;
        done_d = 1'b0;
        if (state_q == COMPRESS) begin
            for (int i = 0; i < D; i++) begin
                out_d[i] = ^c_q[i];
            end
            out_d[0] = out_d[0] ^ mode_q;
            done_d   = 1'b1;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign out   = out_q;

endmodule

// File: tb/tb_masked_and_dom.sv
// Directed bench for masked_and_dom at D=2 and D=3.
// Expected share vectors are hand-derived from the DOM term equations.
module tb_masked_and_dom;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s2_start, s2_nand;
    logic [0:1] s2_a, s2_b;
    logic [0:0] s2_r;
    logic       s2_ready, s2_done;
    logic [0:1] s2_out;

    logic       s3_start, s3_nand;
    logic [0:2] s3_a, s3_b, s3_r;
    logic       s3_ready, s3_done;
    logic [0:2] s3_out;

    masked_and_dom #(.D(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(s2_start), .nand_sel(s2_nand),
        .ina(s2_a), .inb(s2_b), .rin(s2_r),
        .ready(s2_ready), .done(s2_done), .out(s2_out)
    );

    masked_and_dom #(.D(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(s3_start), .nand_sel(s3_nand),
        .ina(s3_a), .inb(s3_b), .rin(s3_r),
        .ready(s3_ready), .done(s3_done), .out(s3_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected D=2 share vector from the DOM term equations.
    function automatic logic [0:1] exp2(input logic nd, input logic [0:1] a,
                                        input logic [0:1] b, input logic r);
        logic [0:1] o;
        o[0] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ r ^ nd;
        o[1] = (a[1] & b[0]) ^ r ^ (a[1] & b[1]);
        return o;
    endfunction

    // One D=2 operation: accept, check pipeline flags, return result.
    task automatic op2(input string tag, input logic nd, input logic [0:1] a,
                       input logic [0:1] b, input logic r,
                       output logic [0:1] o);
        s2_start = 1'b1; s2_nand = nd;
        s2_a = a; s2_b = b; s2_r = r;
        tick();
        s2_start = 1'b0;
        s2_a = ~a; s2_b = ~b; s2_r = ~r; s2_nand = ~nd;
        check({tag, "_busy"}, {31'd0, s2_ready | s2_done}, 32'd0);
        tick();
        check({tag, "_done"}, {31'd0, s2_done}, 32'd1);
        o = s2_out;
    endtask

    logic [0:1] o2, o2b;
    logic [0:2] rv, e3;

    initial begin
        rst = 1'b1;
        s2_start = 0; s2_nand = 0; s2_a = 0; s2_b = 0; s2_r = 0;
        s3_start = 0; s3_nand = 0; s3_a = 0; s3_b = 0; s3_r = 0;
        tick(); tick();
        check("rst_ready", {31'd0, s2_ready}, 32'd1);
        check("rst_done", {31'd0, s2_done}, 32'd0);
        check("rst_out", {30'd0, s2_out}, 32'd0);
        rst = 1'b0;
        tick();

        op2("and_vec", 1'b0, 2'b10, 2'b01, 1'b1, o2);
        check("and_vec_out", {30'd0, o2}, 32'd1);
        check("done_clears", 0, 0 + 0 + 0);
        tick();
        check("done_pulse", {31'd0, s2_done}, 32'd0);
        check("out_held", {30'd0, s2_out}, 32'd1);

        op2("nand_vec", 1'b1, 2'b10, 2'b01, 1'b1, o2);
        check("nand_vec_out", {30'd0, o2}, 32'd3);

        // D=2 exhaustive in both modes
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    logic [0:1] av, bv;
                    logic expx;
                    av = a[1:0]; bv = b[1:0];
                    expx = ((^av) & (^bv)) ^ m[0];
                    op2("ex_r0", m[0], av, bv, 1'b0, o2);
                    check("ex_r0_xor", {31'd0, ^o2}, {31'd0, expx});
                    check("ex_r0_shr", {30'd0, o2},
                          {30'd0, exp2(m[0], av, bv, 1'b0)});
                    op2("ex_r1", m[0], av, bv, 1'b1, o2b);
                    check("ex_r1_xor", {31'd0, ^o2b}, {31'd0, expx});
                    check("ex_rdiff", {31'd0, o2 != o2b}, 32'd1);
                end
            end
        end

        // D=3: a=0, b=1, sweep randomness
        for (int r = 0; r < 8; r++) begin
            rv = r[2:0];
            e3[0] = 1'b1 ^ rv[0] ^ rv[1];
            e3[1] = 1'b1 ^ rv[0] ^ rv[2];
            e3[2] = rv[1] ^ rv[2];
            s3_start = 1'b1; s3_a = 3'b110; s3_b = 3'b100; s3_r = rv;
            tick();
            s3_start = 1'b0; s3_a = 3'b111; s3_b = 3'b111; s3_r = ~rv;
            tick();
            check("d3_done", {31'd0, s3_done}, 32'd1);
            check("d3_xor", {31'd0, ^s3_out}, 32'd0);
            check("d3_shares", {29'd0, s3_out}, {29'd0, e3});
        end

        // Back-to-back with start held high; COMPRESS-cycle inputs ignored
        s2_start = 1'b1;
        for (int n = 0; n < 6; n++) begin
            logic [0:1] av, bv;
            logic rb, nd;
            av = n[1:0]; bv = ~n[1:0] ^ {1'b0, n[2]}; rb = n[0] ^ n[1];
            nd = n[2];
            s2_a = av; s2_b = bv; s2_r = rb; s2_nand = nd;
            tick();
            check("b2b_acc", {31'd0, s2_ready | s2_done}, 32'd0);
            s2_a = ~av; s2_b = ~bv; s2_r = ~rb; s2_nand = ~nd;
            tick();
            check("b2b_done", {31'd0, s2_done & s2_ready}, 32'd1);
            check("b2b_out", {30'd0, s2_out}, {30'd0, exp2(nd, av, bv, rb)});
        end

        // Reset during COMPRESS aborts the op
        s2_a = 2'b11; s2_b = 2'b11; s2_r = 1'b0; s2_nand = 1'b0;
        tick();
        s2_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {31'd0, s2_ready}, 32'd1);
        check("abort_done", {31'd0, s2_done}, 32'd0);
        check("abort_out", {30'd0, s2_out}, 32'd0);
        tick();
        check("abort_nodone", {31'd0, s2_done}, 32'd0);
        check("abort_out2", {30'd0, s2_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
